// File: rtl/led_pwm_driver_pkg.sv
// Shared constants for the LED PWM output stage: channel count, default timing
// parameters and the memory-mapped address of the LED duty register.
package led_pwm_driver_pkg;

  localparam int unsigned LED_CHANNELS      = 8;
  localparam int unsigned DEF_PWM_BITS      = 4;
  localparam int unsigned DEF_PRESCALE      = 16;
  localparam int unsigned DEF_BLINK_PERIODS = 4096;

  // Data memory decodes stores to this address into cfg_we/cfg_sel/cfg_duty.
  localparam logic [31:0] LED_DUTY_ADDR = 32'h0000_7F04;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler, PWM period counter and blink phase generator for the LED driver.
// period_end_o is combinational and marks the last clk of each PWM period.
module led_pwm_timebase
  import led_pwm_driver_pkg::*;
#(
  parameter int unsigned PWM_BITS      = DEF_PWM_BITS,
  parameter int unsigned PRESCALE      = DEF_PRESCALE,
  parameter int unsigned BLINK_PERIODS = DEF_BLINK_PERIODS
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PWM_BITS-1:0] pwm_cnt_o,
  output logic                period_end_o,
  output logic                blink_phase_o
);

  localparam int unsigned      PRE_W   = cnt_width(PRESCALE);
  localparam int unsigned      BLK_W   = cnt_width(BLINK_PERIODS);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_PERIODS - 1);

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic                tick;
  logic                period_end;

  always_comb begin
    tick          = (pre_cnt_q == PRE_MAX);
    period_end    = tick && (pwm_cnt_q == '1);
    pre_cnt_d     = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d     = pwm_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end
    if (period_end) begin
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign pwm_cnt_o     = pwm_cnt_q;
  assign period_end_o  = period_end;
  assign blink_phase_o = blink_phase_q;

endmodule

// File: rtl/led_pwm_driver.sv
// LED pin driver: per-channel PWM brightness and blink, with pattern and duty
// committed only at PWM period boundaries so the pins never glitch.
module led_pwm_driver
  import led_pwm_driver_pkg::*;
#(
  parameter int unsigned PWM_BITS      = DEF_PWM_BITS,
  parameter int unsigned PRESCALE      = DEF_PRESCALE,
  parameter int unsigned BLINK_PERIODS = DEF_BLINK_PERIODS,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LED_CHANNELS-1:0] led_i,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_sel,
  input  logic [PWM_BITS-1:0]     cfg_duty,
  input  logic [LED_CHANNELS-1:0] blink_en_i,
  output logic [LED_CHANNELS-1:0] led_o,
  output logic                    period_o
);

  localparam logic [LED_CHANNELS-1:0] INACTIVE = {LED_CHANNELS{ACTIVE_LOW}};

  logic [PWM_BITS-1:0]     pwm_cnt;
  logic                    period_end;
  logic                    blink_phase;

  logic [PWM_BITS-1:0]     duty_cfg_q [LED_CHANNELS];
  logic [PWM_BITS-1:0]     duty_cfg_d [LED_CHANNELS];
  logic [PWM_BITS-1:0]     duty_act_q [LED_CHANNELS];
  logic [PWM_BITS-1:0]     duty_act_d [LED_CHANNELS];
  logic [LED_CHANNELS-1:0] pat_act_q, pat_act_d;
  logic [LED_CHANNELS-1:0] led_q, led_d;
  logic                    period_q, period_d;
  logic [LED_CHANNELS-1:0] lit;

  led_pwm_timebase #(
    .PWM_BITS      (PWM_BITS),
    .PRESCALE      (PRESCALE),
    .BLINK_PERIODS (BLINK_PERIODS)
  ) u_timebase (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm_cnt_o     (pwm_cnt),
    .period_end_o  (period_end),
    .blink_phase_o (blink_phase)
  );

  always_comb begin
    duty_cfg_d = duty_cfg_q;
    duty_act_d = duty_act_q;
    pat_act_d  = pat_act_q;
    period_d   = period_end;
    // Commit reads the pre-write duty_cfg_q, so a coincident write lands one period later.
    if (period_end) begin
      duty_act_d = duty_cfg_q;
      pat_act_d  = led_i;
    end
    if (cfg_we) begin
      duty_cfg_d[cfg_sel] = cfg_duty;
    end
  end

  always_comb begin
    lit = '0;
    for (int unsigned i = 0; i < LED_CHANNELS; i++) begin
      lit[i] = pat_act_q[i]
            && ((duty_act_q[i] == '1) || (pwm_cnt < duty_act_q[i]))
            && (!blink_en_i[i] || blink_phase);
    end
    led_d = lit ^ INACTIVE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_cfg_q <= '{default: '1};
      duty_act_q <= '{default: '1};
      pat_act_q  <= '0;
      led_q      <= INACTIVE;
      period_q   <= 1'b0;
    end else begin
      duty_cfg_q <= duty_cfg_d;
      duty_act_q <= duty_act_d;
      pat_act_q  <= pat_act_d;
      led_q      <= led_d;
      period_q   <= period_d;
    end
  end

  assign led_o    = led_q;
  assign period_o = period_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with PRESCALE=2, BLINK_PERIODS=4 (32 clk per PWM period).
module tb_led_pwm_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] led_i;
  logic       cfg_we;
  logic [2:0] cfg_sel;
  logic [3:0] cfg_duty;
  logic [7:0] blink_en_i;
  logic [7:0] led_o;
  logic       period_o;

  int errors = 0;
  int checks = 0;

  led_pwm_driver #(
    .PWM_BITS      (4),
    .PRESCALE      (2),
    .BLINK_PERIODS (4),
    .ACTIVE_LOW    (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_i      (led_i),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_duty   (cfg_duty),
    .blink_en_i (blink_en_i),
    .led_o      (led_o),
    .period_o   (period_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advances until period_o is seen; returns the number of clk edges taken.
  task automatic wait_period(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (period_o !== 1'b1 && n < 100);
    chk("period_seen", {31'd0, period_o}, 32'd1);
  endtask

  // One PWM period of samples: bit k of v is led_o[ch] k+1 edges after the call.
  task automatic cap32(input int ch, output logic [31:0] v, output logic [7:0] others);
    v      = '0;
    others = '0;
    for (int k = 0; k < 32; k++) begin
      step(1);
      v[k]   = led_o[ch];
      others = others | (led_o & ~(8'd1 << ch));
    end
  endtask

  initial begin
    int          n;
    int          cnt;
    int          on1, off1, on2;
    logic [31:0] v;
    logic [7:0]  oth;

    rst_n = 1'b0; led_i = 8'h00; cfg_we = 1'b0; cfg_sel = 3'd0;
    cfg_duty = 4'd0; blink_en_i = 8'h00;
    step(3);
    chk("reset_led", led_o, 8'h00);
    chk("reset_period", period_o, 1'b0);

    // Full-on pattern appears one clk after the first period_o.
    rst_n = 1'b1; led_i = 8'hA5;
    wait_period(n);
    chk("first_period_latency", n, 32);
    chk("led_before_commit", led_o, 8'h00);
    step(1);
    chk("period_one_cycle", period_o, 1'b0);
    cnt = (led_o == 8'hA5) ? 1 : 0;
    for (int k = 1; k < 32; k++) begin
      step(1);
      if (led_o == 8'hA5) cnt++;
    end
    chk("full_on_steady", cnt, 32);
    wait_period(n);

    // ch0 duty 4 -> 8 of 32 clks lit at the start of each period.
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_duty = 4'd4; led_i = 8'h01;
    step(1);
    cfg_we = 1'b0;
    wait_period(n);
    cap32(0, v, oth);
    chk("duty4_shape", v, 32'h0000_00FF);
    chk("duty4_others", oth, 8'h00);

    cfg_we = 1'b1; cfg_duty = 4'd0;
    step(1);
    cfg_we = 1'b0;
    wait_period(n);
    cap32(0, v, oth);
    chk("duty0_off", v, 32'h0);
    chk("duty0_others", oth, 8'h00);

    // Write on the exact period_end cycle: old duty holds one more period.
    step(31);
    cfg_we = 1'b1; cfg_sel = 3'd1; cfg_duty = 4'd8; led_i = 8'h02;
    step(1);
    cfg_we = 1'b0;
    chk("coincident_period", period_o, 1'b1);
    cap32(1, v, oth);
    chk("coincident_old_duty", v, 32'hFFFF_FFFF);
    chk("coincident_others", oth, 8'h00);
    cap32(1, v, oth);
    chk("coincident_new_duty", v, 32'h0000_FFFF);

    // led_i glitch within a period is ignored; the 0x00 present at period_end commits.
    led_i = 8'h00;
    v = '0; oth = '0;
    for (int k = 0; k < 32; k++) begin
      if (k == 4)  led_i = 8'hFF;
      if (k == 12) led_i = 8'h00;
      step(1);
      v[k] = led_o[1];
      oth  = oth | (led_o & 8'hFD);
    end
    chk("glitch_ignored_ch1", v, 32'h0000_FFFF);
    chk("glitch_ignored_others", oth, 8'h00);
    cap32(1, v, oth);
    chk("pattern_zero_ch1", v, 32'h0);
    chk("pattern_zero_others", oth, 8'h00);

    // Mid-period reset while all channels are full-on.
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_duty = 4'hF;
    step(1);
    cfg_sel = 3'd1;
    step(1);
    cfg_we = 1'b0; led_i = 8'hFF;
    wait_period(n);
    step(5);
    chk("all_on_before_reset", led_o, 8'hFF);
    rst_n = 1'b0;
    step(1);
    chk("reset_mid_led", led_o, 8'h00);
    chk("reset_mid_period", period_o, 1'b0);
    rst_n = 1'b1; led_i = 8'h02; blink_en_i = 8'h02;
    wait_period(n);
    chk("restart_latency", n, 32);
    chk("restart_led_off", led_o, 8'h00);

    // Blink: first commit lands 3 periods into the on-phase, then 4 off, 4 on.
    on1 = 0; off1 = 0; on2 = 0;
    for (int j = 1; j <= 352; j++) begin
      step(1);
      if (led_o[1]) begin
        if (j <= 96)       on1++;
        else if (j <= 224) off1++;
        else               on2++;
      end
    end
    chk("blink_on_first", on1, 96);
    chk("blink_off", off1, 0);
    chk("blink_on_second", on2, 128);
    step(8);
    chk("blink_off_again", led_o[1], 1'b0);
    blink_en_i = 8'h00;
    step(1);
    chk("blink_disable_fast", led_o[1], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
